// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size encodings and
// the bit layout of a queued request entry.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } size_e;

  // Entry layout, LSB first: wdata | size | wstrb | wr | word index (AW bits)
  localparam int unsigned WDATA_W   = 32;
  localparam int unsigned WDATA_LSB = 0;
  localparam int unsigned SIZE_W    = 3;
  localparam int unsigned SIZE_LSB  = 32;
  localparam int unsigned WSTRB_W   = 4;
  localparam int unsigned WSTRB_LSB = 35;
  localparam int unsigned WR_BIT    = 39;
  localparam int unsigned ADDR_LSB  = 40;
  localparam int unsigned ENT_FIX_W = 40;

  function automatic int unsigned ent_width(input int unsigned aw);
    return ENT_FIX_W + aw;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-side SRAM-like request/response bus (data_req/data_addr_ok/data_data_ok).
interface dmem_responder_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [2:0]  data_size;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_size, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_size, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with head-data output and occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// In-order data-memory responder: request FIFO with empty-queue bypass in front of a
// 1-cycle synchronous SRAM. Optional issue stalling via macro DMEM_RESPONDER_STALL_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  dmem_responder_if.slave       bus,
  output logic                  sram_en,
  output logic [3:0]            sram_wen,
  output logic [AW-1:0]         sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam int unsigned EW = ent_width(AW);

  logic [EW-1:0]              in_ent, head_ent, iss_ent;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(DEPTH+1)-1:0] fifo_cnt_unused;
  logic                       accept, issue, push, pop, stall;
  logic                       resp_pending_q, resp_rd_q;
  logic                       unused_bits;

  assign in_ent = {bus.data_addr[AW+1:2], bus.data_wr, bus.data_wstrb,
                   bus.data_size, bus.data_wdata};

`ifdef DMEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Head of the queue always wins; an incoming request bypasses only an empty queue.
  assign bus.data_addr_ok = !fifo_full;
  assign accept  = bus.data_req && !fifo_full;
  assign issue   = !stall && (!fifo_empty || accept);
  assign pop     = issue && !fifo_empty;
  assign push    = accept && !(issue && fifo_empty);
  assign iss_ent = fifo_empty ? in_ent : head_ent;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_ent),
    .rdata_o (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt_unused)
  );

  always_comb begin
    sram_en    = issue;
    sram_wen   = (issue && iss_ent[WR_BIT]) ? iss_ent[WSTRB_LSB +: WSTRB_W] : '0;
    sram_addr  = iss_ent[ADDR_LSB +: AW];
    sram_wdata = iss_ent[WDATA_LSB +: WDATA_W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_pending_q <= 1'b0;
      resp_rd_q      <= 1'b0;
    end else begin
      resp_pending_q <= issue;
      resp_rd_q      <= issue && !iss_ent[WR_BIT];
    end
  end

  assign bus.data_data_ok = resp_pending_q;
  assign bus.data_rdata   = (resp_pending_q && resp_rd_q) ? sram_rdata : '0;

  assign unused_bits = ^{bus.data_addr[31:AW+2], bus.data_addr[1:0],
                         iss_ent[SIZE_LSB +: SIZE_W]};

endmodule
